// File: rtl/cpu_pkg.sv
// Shared constants for the CPU MULT/DIV sequencer: default width, op and state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply step or restoring divide step on magnitudes.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 op,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    // MULT: acc = {partial_product, remaining_multiplier}; DIV: acc = {remainder, dividend/quotient}
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     shifted;
    logic               borrow;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_acc;

    // Both step flavours are computed; op selects which one is written back.
    always_comb begin
        add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        mul_acc = {add_sum, acc_i[WIDTH-1:1]};

        // Remainder is always below the divisor, so the trial difference fits in WIDTH bits.
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        borrow  = shifted < {1'b0, opnd_i};
        rem_sub = shifted[WIDTH-1:0] - opnd_i;
        rem_new = borrow ? shifted[WIDTH-1:0] : rem_sub;
        div_acc = {rem_new, acc_i[WIDTH-2:0], ~borrow};

        acc_o = (op == OP_DIV) ? div_acc : mul_acc;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle signed MULT/DIV sequencer: WIDTH iterations on magnitudes, then sign fix-up into hi/lo.
// Latency: done 34 cycles after start is sampled (WIDTH=32); 1 cycle for divide by zero.
// Backpressure: none; start is only accepted in IDLE and ignored (not queued) while busy.
module muldiv_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_q, op_d;
    logic               neg_q, neg_d;      // operand signs differ
    logic               sa_q, sa_d;        // sign of a, for the remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;

    // Magnitudes are unsigned, so |0x80000000| is represented correctly as 2^(WIDTH-1).
    always_comb begin
        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Next-state, datapath load/iterate and sign fix-up; outputs are registered from here.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        prod_fix = neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    sa_d    = a[WIDTH-1];
                    count_d = '0;
                    if (op == OP_DIV && b == '0) begin
                        // hi/lo deliberately untouched on the zero-divisor path
                        state_d = DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        acc_d   = (op == OP_MULT) ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
                        opnd_d  = (op == OP_MULT) ? mag_a : mag_b;
                    end
                end
            end
            RUN: begin
                acc_d   = step_acc;
                busy_d  = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MULT;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed checks of muldiv_seq against a signed-arithmetic reference model.
// Latency: checks done timing (34 cycles, or 1 for divide by zero) and busy length.
// Backpressure: checks that start while busy is ignored and that reset aborts cleanly.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural HI/LO as the model expects them to be right now
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS-style signed MULT/DIV using 64-bit signed arithmetic.
    task automatic model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        e_dz = 1'b0;
        e_hi = model_hi;
        e_lo = model_lo;
        if (op_i == 1'b0) begin
            p    = sa * sb;
            e_hi = p[63:32];
            e_lo = p[31:0];
        end else if (b_i == 32'd0) begin
            e_dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e_lo = q[31:0];
            e_hi = r[31:0];
        end
    endtask

    // Issue one operation and watch 36 cycles. glitch_cyc: cycle in which a second start is
    // driven; reset_cyc: cycle in which reset is driven (0 disables either).
    task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int glitch_cyc, input int reset_cyc);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        int          n_done;
        int          done_cyc;
        int          busy_cnt;
        int          dz_cnt;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        n_done   = 0;
        done_cyc = -1;
        busy_cnt = 0;
        dz_cnt   = 0;
        got_hi   = '0;
        got_lo   = '0;
        model(op_i, a_i, b_i, e_hi, e_lo, e_dz);

        @(negedge clk);
        op    = op_i;
        a     = a_i;
        b     = b_i;
        start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                done_cyc = c;
                got_hi   = hi;
                got_lo   = lo;
            end
            if (div_zero) dz_cnt++;
            if (busy) busy_cnt++;
            if (reset_cyc > 0 && c == reset_cyc + 1) begin
                check("reset_abort_busy", {63'd0, busy}, 64'd0);
                check("reset_abort_hi", {32'd0, hi}, 64'd0);
                check("reset_abort_lo", {32'd0, lo}, 64'd0);
            end
            start = (c == glitch_cyc);
            reset = (c == reset_cyc);
            if (c == glitch_cyc) begin
                op = ~op_i;
                a  = $urandom;
                b  = 32'd0;
            end else begin
                op = op_i;
                a  = a_i;
                b  = b_i;
            end
        end
        start = 1'b0;
        reset = 1'b0;

        if (reset_cyc > 0) begin
            check("reset_no_done", 64'(n_done), 64'd0);
            model_hi = '0;
            model_lo = '0;
        end else begin
            check("done_count", 64'(n_done), 64'd1);
            check("done_cycle", 64'(done_cyc), e_dz ? 64'd1 : 64'd34);
            check("busy_cycles", 64'(busy_cnt), e_dz ? 64'd0 : 64'd33);
            check("div_zero_cycles", 64'(dz_cnt), e_dz ? 64'd1 : 64'd0);
            check("hi_at_done", {32'd0, got_hi}, {32'd0, e_hi});
            check("lo_at_done", {32'd0, got_lo}, {32'd0, e_lo});
            check("hi_hold", {32'd0, hi}, {32'd0, e_hi});
            check("lo_hold", {32'd0, lo}, {32'd0, e_lo});
            model_hi = e_hi;
            model_lo = e_lo;
        end
    endtask

    function automatic logic [31:0] pick_operand(input int sel);
        logic [31:0] v;
        case (sel)
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h0000_0001;
            4:       v = 32'h7FFF_FFFF;
            5:       v = $urandom_range(0, 255);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        // Directed cases
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(1'b1, 32'h0000_0451, 32'h0000_0020, 0, 0);   // leaves hi=0x11, lo=0x22
        check("prior_hi", {32'd0, hi}, 64'h11);
        check("prior_lo", {32'd0, lo}, 64'h22);
        run_op(1'b1, 32'd5, 32'd0, 0, 0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(1'b0, 32'd3, 32'd4, 10, 0);
        run_op(1'b1, 32'd100, 32'd7, 0, 10);
        run_op(1'b0, 32'd2, 32'd3, 0, 0);

        // Random mix including corner operands
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), pick_operand($urandom_range(0, 9)),
                   pick_operand($urandom_range(0, 9)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
